window_generator: RTL and testbench

//  Streaming neighbourhood builder placed directly upstream of MeanFilter.

---
 rtl/img_pkg.sv | 19 +
 rtl/line_buffer.sv | 36 +++
 rtl/window_generator.sv | 115 +++++++++++
 tb/tb_window_generator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared image-processing helpers: default pixel width, counter width sizing and
// the flattened-window slice index used by window_generator and MeanFilter benches.
package img_pkg;

  localparam int COLOR_WIDTH = 12;

  // Bits needed to count 0..value-1, never less than one.
  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int idx(input int r, input int c, input int window_width);
    return r * window_width + c;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of delay: a single-port RAM walked by a circular address, read
// before written, so dout is the pixel accepted exactly depth shifts earlier.
module line_buffer
  import img_pkg::*;
#(
  parameter int color_width = COLOR_WIDTH,
  parameter int depth       = 640
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic [color_width-1:0] din,
  output logic [color_width-1:0] dout
);

  localparam int AW = clog2_min1(depth);
  localparam logic [AW-1:0] ADDR_LAST = AW'(depth - 1);

  logic [color_width-1:0] mem [depth];
  logic [AW-1:0]          addr;

  assign dout = mem[addr];

  always_ff @(posedge clk) begin
    if (shift_en) mem[addr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (shift_en) begin
      addr <= (addr == ADDR_LAST) ? '0 : addr + AW'(1);
    end
  end

endmodule

// File: rtl/window_generator.sv
// Streaming window_width x window_width neighbourhood builder feeding MeanFilter.
// Optional WINGEN_SOF_EN adds in_sof to force the accepted pixel to position (0,0).
module window_generator
  import img_pkg::*;
#(
  parameter int color_width  = COLOR_WIDTH,
  parameter int window_width = 3,
  parameter int image_width  = 640,
  parameter int image_height = 480
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic                                             in_enable,
  input  logic [color_width-1:0]                           in_data,
`ifdef WINGEN_SOF_EN
  input  logic                                             in_sof,
`endif
  output logic                                             out_enable,
  output logic [color_width*window_width*window_width-1:0] out_data
);

  localparam int COL_W = clog2_min1(image_width);
  localparam int ROW_W = clog2_min1(image_height);
  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(image_width - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(image_height - 1);
  localparam logic [COL_W-1:0] COL_FIRST = COL_W'(window_width - 1);
  localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(window_width - 1);

  logic [COL_W-1:0] col, col_cur;
  logic [ROW_W-1:0] row, row_cur;
  logic             sof_hit;

`ifdef WINGEN_SOF_EN
  assign sof_hit = in_sof & in_enable;
`else
  assign sof_hit = 1'b0;
`endif

  // Position of the pixel being accepted this cycle; a start-of-frame overrides the count.
  always_comb begin
    col_cur = col;
    row_cur = row;
    if (sof_hit) begin
      col_cur = '0;
      row_cur = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= '0;
    end else if (in_enable) begin
      if (col_cur == COL_LAST) begin
        col <= '0;
        row <= (row_cur == ROW_LAST) ? '0 : row_cur + ROW_W'(1);
      end else begin
        col <= col_cur + COL_W'(1);
        row <= row_cur;
      end
    end
  end

  // Newest window column: slice r of taps is window row r, the live pixel at the bottom.
  logic [window_width*color_width-1:0] taps;

  assign taps[(window_width-1)*color_width +: color_width] = in_data;

  for (genvar k = 0; k < window_width - 1; k++) begin : g_lb
    line_buffer #(
      .color_width (color_width),
      .depth       (image_width)
    ) u_line_buffer (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (in_enable),
      .din      (taps[(window_width-1-k)*color_width +: color_width]),
      .dout     (taps[(window_width-2-k)*color_width +: color_width])
    );
  end

  // Stage p0: window register and its validity flag
  logic [color_width-1:0] win_p0 [window_width][window_width];
  logic                   vld_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      for (int r = 0; r < window_width; r++) begin
        for (int c = 0; c < window_width; c++) begin
          win_p0[r][c] <= '0;
        end
      end
    end else begin
      vld_p0 <= in_enable && (row_cur >= ROW_FIRST) && (col_cur >= COL_FIRST);
      if (in_enable) begin
        for (int r = 0; r < window_width; r++) begin
          for (int c = 0; c < window_width - 1; c++) begin
            win_p0[r][c] <= win_p0[r][c+1];
          end
          win_p0[r][window_width-1] <= taps[r*color_width +: color_width];
        end
      end
    end
  end

  assign out_enable = vld_p0;

  for (genvar r = 0; r < window_width; r++) begin : g_row
    for (genvar c = 0; c < window_width; c++) begin : g_col
      assign out_data[idx(r, c, window_width)*color_width +: color_width] = win_p0[r][c];
    end
  end

endmodule

// File: tb/tb_window_generator.sv
// Directed bench for window_generator on an 8x4 image with 3x3 windows; pixel (r,c)=r*16+c.
module tb_window_generator;

  localparam int CW = 12;
  localparam int WW = 3;
  localparam int IW = 8;
  localparam int IH = 4;
  localparam int OW = CW * WW * WW;
  localparam int NPIX = IW * IH;

  logic          clk;
  logic          rst_n;
  logic          in_enable;
  logic [CW-1:0] in_data;
  logic          in_sof;
  logic          out_enable;
  logic [OW-1:0] out_data;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [CW-1:0] pix;
    logic          exp_en;
    logic [OW-1:0] exp_data;
  } vec_t;

  vec_t tbl [NPIX];

  window_generator #(
    .color_width  (CW),
    .window_width (WW),
    .image_width  (IW),
    .image_height (IH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_enable  (in_enable),
    .in_data    (in_data),
`ifdef WINGEN_SOF_EN
    .in_sof     (in_sof),
`endif
    .out_enable (out_enable),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [OW-1:0] exp_window(input int r, input int c);
    logic [OW-1:0] d;
    d = '0;
    for (int rr = 0; rr < WW; rr++) begin
      for (int cc = 0; cc < WW; cc++) begin
        d[(rr*WW+cc)*CW +: CW] = CW'((r - WW + 1 + rr) * 16 + (c - WW + 1 + cc));
      end
    end
    return d;
  endfunction

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic en, input logic [CW-1:0] pix, input logic sof);
    in_enable = en;
    in_data   = pix;
    in_sof    = sof;
    @(posedge clk);
    #1;
    in_sof = 1'b0;
  endtask

  task automatic run_frame(input string tag, input int stall_after, input bit sof_first);
    int nvalid;
    nvalid = 0;
    for (int i = 0; i < NPIX; i++) begin
      step(1'b1, tbl[i].pix, sof_first && (i == 0));
      if (out_enable) nvalid++;
      check_bit($sformatf("%s en px%0d", tag, i), out_enable, tbl[i].exp_en);
      if (tbl[i].exp_en)
        check_vec($sformatf("%s data px%0d", tag, i), out_data, tbl[i].exp_data);
      if (i == stall_after) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 12'hFFF, 1'b0);
          check_bit($sformatf("%s stall en %0d", tag, s), out_enable, 1'b0);
          check_vec($sformatf("%s stall hold %0d", tag, s), out_data, tbl[i].exp_data);
        end
      end
    end
    check_int($sformatf("%s valid count", tag), nvalid, (IW - WW + 1) * (IH - WW + 1));
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) begin
      tbl[i].pix      = CW'((i / IW) * 16 + (i % IW));
      tbl[i].exp_en   = ((i / IW) >= WW - 1) && ((i % IW) >= WW - 1);
      tbl[i].exp_data = tbl[i].exp_en ? exp_window(i / IW, i % IW) : '0;
    end

    rst_n     = 1'b0;
    in_enable = 1'b0;
    in_data   = '0;
    in_sof    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_bit("reset en", out_enable, 1'b0);
    check_vec("reset data", out_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    run_frame("f1", -1, 1'b0);
    run_frame("f2", -1, 1'b0);
    run_frame("stall", 19, 1'b0);

    // Abort mid row 2, then restart from (0,0).
    for (int i = 0; i < 20; i++) step(1'b1, tbl[i].pix, 1'b0);
    check_bit("pre-reset en", out_enable, 1'b1);
    #2;
    rst_n     = 1'b0;
    in_enable = 1'b0;
    #1;
    check_bit("async reset en", out_enable, 1'b0);
    check_vec("async reset data", out_data, '0);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_frame("post-reset", -1, 1'b0);

`ifdef WINGEN_SOF_EN
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 12'h5A5, 1'b0);
      check_bit($sformatf("pre-sof en %0d", i), out_enable, 1'b0);
    end
    run_frame("sof", -1, 1'b1);
`endif

    in_enable = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
